// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Purpose  : Response codes, FSM encodings and address-decode helpers shared
//            by the AXI-lite SRAM slave.
// Revision : 1.0
// ============================================================================
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return (addr - base) >> 3;
   endfunction

   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
      return (addr >= base) && (word_index(addr, base) < depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_sram_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : lat_cnt
// Purpose  : Loadable down-counter that paces one response engine.
// Revision : 1.0
// ============================================================================
module lat_cnt #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   // High on the cycle whose decrement lands the count on zero.
   assign zero_o = (cnt_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/axi_lite_sram.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram
// Purpose  : AXI-lite 64-bit word SRAM slave with programmable read/write
//            response latency and DECERR on out-of-range addresses.
// Revision : 1.0
// ============================================================================
module axi_lite_sram
   import axi_lite_pkg::*;
#(
   parameter int          MEM_DEPTH = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          RD_LAT    = 2,
   parameter int          WR_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          AW      = $clog2(MEM_DEPTH);
   localparam int          MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int          CW      = $clog2(MAX_LAT) + 1;
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);
   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

   logic [63:0] mem_q [MEM_DEPTH];

   rd_state_e   rstate_q;
   wr_state_e   wstate_q;
   logic [31:0] raddr_q;
   logic        arready_q, rvalid_q, bvalid_q;
   logic [63:0] rdata_q;
   logic [1:0]  rresp_q, bresp_q;

   logic          ar_hs, aw_hs, rd_zero, wr_zero, rd_hit, wr_hit;
   logic [31:0]   rd_addr;
   logic [AW-1:0] rd_idx, wr_idx;
   logic [63:0]   rd_word;

   // The 1-cycle latency case samples straight off the bus address.
   assign rd_addr = (rstate_q == R_IDLE) ? araddr : raddr_q;
   assign rd_hit  = addr_in_range(rd_addr, BASE_ADDR, DEPTH_W);
   assign rd_idx  = AW'(word_index(rd_addr, BASE_ADDR));
   assign rd_word = rd_hit ? mem_q[rd_idx] : '0;

   assign wr_hit  = addr_in_range(awaddr, BASE_ADDR, DEPTH_W);
   assign wr_idx  = AW'(word_index(awaddr, BASE_ADDR));

   assign ar_hs   = arvalid && arready_q;
   assign aw_hs   = (wstate_q == W_IDLE) && awvalid && wvalid && !rst;

   lat_cnt #(.WIDTH(CW)) u_rd_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ar_hs),
      .load_val_i (RD_LOAD),
      .dec_i      (rstate_q == R_WAIT),
      .zero_o     (rd_zero)
   );

   lat_cnt #(.WIDTH(CW)) u_wr_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (aw_hs),
      .load_val_i (WR_LOAD),
      .dec_i      (wstate_q == W_WAIT),
      .zero_o     (wr_zero)
   );

   always_ff @(posedge clk) begin
      if (aw_hs && wr_hit) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) mem_q[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         raddr_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  raddr_q   <= araddr;
                  arready_q <= 1'b0;
                  if (RD_LAT == 1) begin
                     rdata_q  <= rd_word;
                     rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
                     rvalid_q <= 1'b1;
                     rstate_q <= R_RESP;
                  end else begin
                     rstate_q <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (rd_zero) begin
                  rdata_q  <= rd_word;
                  rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
                  rvalid_q <= 1'b1;
                  rstate_q <= R_RESP;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q <= W_IDLE;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs) begin
                  bresp_q <= wr_hit ? RESP_OKAY : RESP_DECERR;
                  if (WR_LAT == 1) begin
                     bvalid_q <= 1'b1;
                     wstate_q <= W_RESP;
                  end else begin
                     wstate_q <= W_WAIT;
                  end
               end
            end
            W_WAIT: begin
               if (wr_zero) begin
                  bvalid_q <= 1'b1;
                  wstate_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign awready = aw_hs;
   assign wready  = aw_hs;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_sram
// Purpose  : Directed self-checking bench for the AXI-lite SRAM slave.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_sram;
   import axi_lite_pkg::*;

   localparam int          MEM_DEPTH = 4096;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          RD_LAT    = 2;
   localparam int          WR_LAT    = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr, awaddr;
   logic        arvalid, arready, rvalid, rready;
   logic [63:0] rdata, wdata;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [7:0]  wstrb;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_lite_sram #(
      .MEM_DEPTH (MEM_DEPTH),
      .BASE_ADDR (BASE),
      .RD_LAT    (RD_LAT),
      .WR_LAT    (WR_LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [63:0] exp_d, input logic [1:0] exp_r);
      int k;
      araddr  = addr;
      arvalid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!arready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk_val({tag, ".arready"}, 64'(arready), 64'd1);
      @(posedge clk);
      #1 arvalid = 1'b0;
      k = 1;
      @(negedge clk);
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk_val({tag, ".rlat"}, 64'(k), 64'(RD_LAT));
      chk_val({tag, ".rdata"}, rdata, exp_d);
      chk_val({tag, ".rresp"}, 64'(rresp), 64'(exp_r));
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] d,
                           input logic [7:0] strb, input logic [1:0] exp_r);
      int k;
      awaddr  = addr;
      wdata   = d;
      wstrb   = strb;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      k = 0;
      @(negedge clk);
      while (!awready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk_val({tag, ".awready"}, 64'(awready), 64'd1);
      chk_val({tag, ".wready"}, 64'(wready), 64'd1);
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      k = 1;
      @(negedge clk);
      while (!bvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk_val({tag, ".blat"}, 64'(k), 64'(WR_LAT));
      chk_val({tag, ".bresp"}, 64'(bresp), 64'(exp_r));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      rst = 1'b1;
      arvalid = 1'b0; araddr = '0; rready = 1'b1;
      awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_val("rst.arready", 64'(arready), 64'd1);
      chk_val("rst.rvalid", 64'(rvalid), 64'd0);
      chk_val("rst.rdata", rdata, 64'd0);
      chk_val("rst.rresp", 64'(rresp), 64'd0);
      chk_val("rst.awready", 64'(awready), 64'd0);
      chk_val("rst.wready", 64'(wready), 64'd0);
      chk_val("rst.bvalid", 64'(bvalid), 64'd0);
      chk_val("rst.bresp", 64'(bresp), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic write/read of word 1
      do_write("w1", BASE + 32'h08, 64'h1122_3344_5566_7788, 8'hFF, RESP_OKAY);
      do_read("r1", BASE + 32'h08, 64'h1122_3344_5566_7788, RESP_OKAY);
      @(negedge clk);
      chk_val("r1.rvalid_drop", 64'(rvalid), 64'd0);
      chk_val("r1.arready_back", 64'(arready), 64'd1);
      @(posedge clk);
      #1;

      // Byte strobes on word 2
      do_write("w2.clr", BASE + 32'h10, 64'h0, 8'hFF, RESP_OKAY);
      do_write("w2.lo", BASE + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RESP_OKAY);
      do_read("r2.lo", BASE + 32'h10, 64'h0000_0000_FFFF_FFFF, RESP_OKAY);
      do_write("w2.hi", BASE + 32'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, RESP_OKAY);
      do_write("w2.none", BASE + 32'h10, 64'h5555_5555_5555_5555, 8'h00, RESP_OKAY);
      do_read("r2.hi", BASE + 32'h10, 64'hAAAA_AAAA_FFFF_FFFF, RESP_OKAY);

      // wvalid without awvalid is not consumed
      awaddr = BASE + 32'h20; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF;
      wvalid = 1'b1; awvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_val("wonly.wready", 64'(wready), 64'd0);
         chk_val("wonly.bvalid", 64'(bvalid), 64'd0);
      end
      @(posedge clk);
      #1 awvalid = 1'b1;
      @(negedge clk);
      chk_val("wonly.awready_hs", 64'(awready), 64'd1);
      chk_val("wonly.wready_hs", 64'(wready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk_val("wonly.awready_pulse", 64'(awready), 64'd0);
      chk_val("wonly.wready_pulse", 64'(wready), 64'd0);
      chk_val("wonly.bvalid", 64'(bvalid), 64'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk);
      #1;
      do_read("wonly.rd", BASE + 32'h20, 64'hDEAD_BEEF_CAFE_F00D, RESP_OKAY);

      // Read response back-pressure
      rready = 1'b0;
      araddr = BASE + 32'h08; arvalid = 1'b1;
      @(posedge clk);
      #1 arvalid = 1'b0;
      k = 0;
      @(negedge clk);
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_val("stall.rvalid", 64'(rvalid), 64'd1);
         chk_val("stall.rdata", rdata, 64'h1122_3344_5566_7788);
         chk_val("stall.rresp", 64'(rresp), 64'd0);
         chk_val("stall.arready", 64'(arready), 64'd0);
      end
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_val("stall.rvalid_drop", 64'(rvalid), 64'd0);
      chk_val("stall.arready_back", 64'(arready), 64'd1);
      @(posedge clk);
      #1;

      // Out-of-range accesses and ignored low address bits
      do_write("w0", BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, RESP_OKAY);
      do_read("oor.rd", 32'h7FFF_FFF8, 64'h0, RESP_DECERR);
      do_write("oor.wr", BASE + 32'(8 * MEM_DEPTH), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_DECERR);
      do_read("oor.w0", BASE, 64'h0123_4567_89AB_CDEF, RESP_OKAY);
      do_read("lowbits", BASE + 32'h0F, 64'h1122_3344_5566_7788, RESP_OKAY);

      // Read sample and write commit to word 3 on the same edge
      do_write("w3", BASE + 32'h18, 64'h3333_3333_3333_3333, 8'hFF, RESP_OKAY);
      araddr = BASE + 32'h18; arvalid = 1'b1;
      @(negedge clk);
      chk_val("raw.arready", 64'(arready), 64'd1);
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      awaddr = BASE + 32'h18; wdata = 64'h4444_4444_4444_4444; wstrb = 8'hFF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk_val("raw.awready", 64'(awready), 64'd1);
      @(posedge clk);
      #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk_val("raw.rvalid", 64'(rvalid), 64'd1);
      chk_val("raw.old", rdata, 64'h3333_3333_3333_3333);
      chk_val("raw.bvalid", 64'(bvalid), 64'd1);
      @(posedge clk);
      #1;
      do_read("raw.new", BASE + 32'h18, 64'h4444_4444_4444_4444, RESP_OKAY);

      // Reset while the read engine is waiting
      araddr = BASE + 32'h08; arvalid = 1'b1;
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_val("rstwait.arready", 64'(arready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk_val("rstwait.rvalid", 64'(rvalid), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      do_read("post_rst", BASE + 32'h08, 64'h1122_3344_5566_7788, RESP_OKAY);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
